// File: rtl/pipe_controller_pkg.sv
// Shared definitions for the pipeline controller: opcode fields, branch
// condition codes, ALU operation codes, FSM states and the control bundle
// that travels down the D->E->M->W control pipeline.
package pipe_controller_pkg;

  // instr[15:14]
  typedef enum logic [1:0] {
    OP1_LD  = 2'b00,
    OP1_ST  = 2'b01,
    OP1_IMM = 2'b10,
    OP1_ALU = 2'b11
  } op1_e;

  // instr[13:11] inside the immediate/branch group
  typedef enum logic [2:0] {
    OP2_LI  = 3'b000,
    OP2_B   = 3'b100,
    OP2_BCC = 3'b111
  } op2_e;

  // instr[10:8] of a Bcc; codes 1xx are never taken
  typedef enum logic [2:0] {
    COND_BE  = 3'b000,
    COND_BLT = 3'b001,
    COND_BLE = 3'b010,
    COND_BNE = 3'b011
  } cond_e;

  // instr[7:4] inside the ALU group
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_CMP = 4'b0101,
    ALU_MOV = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SLR = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_IN  = 4'b1011,
    ALU_OUT = 4'b1101,
    ALU_HLT = 4'b1111
  } alu_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic [3:0] aluControl;
    logic       jump;
    logic       bcc;
    logic [2:0] cond;
    logic       setFlags;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // flags = {S, Z, V, C}
  function automatic logic condMet(input logic [2:0] cond, input logic [3:0] flags);
    logic met;
    met = 1'b0;
    case (cond)
      COND_BE:  met = flags[2];
      COND_BLT: met = flags[3] ^ flags[1];
      COND_BLE: met = flags[2] | (flags[3] ^ flags[1]);
      COND_BNE: met = ~flags[2];
      default:  met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/pipe_controller_decode.sv
// Combinational instruction decoder.
//   instrD  : 16-bit instruction in the decode stage
//   ctrlD   : control bundle for that instruction (all zero for undefined
//             encodings)
//   HALT_EN : 1 = HLT raises the halt bit; 0 = HLT decodes as a NOP
module ctrl_decode
  import pipe_controller_pkg::*;
#(
  parameter bit HALT_EN = 1'b1
) (
  input  logic [15:0] instrD,
  output ctrl_t       ctrlD
);

  always_comb begin
    ctrlD = CTRL_BUBBLE;
    case (instrD[15:14])
      OP1_LD: begin
        ctrlD.aluControl = ALU_ADD;
        ctrlD.aluSrc     = 1'b1;
        ctrlD.regWrite   = 1'b1;
        ctrlD.memToReg   = 1'b1;
      end
      OP1_ST: begin
        ctrlD.aluControl = ALU_ADD;
        ctrlD.aluSrc     = 1'b1;
        ctrlD.memWrite   = 1'b1;
      end
      OP1_IMM: begin
        case (instrD[13:11])
          OP2_LI: begin
            ctrlD.aluControl = ALU_MOV;
            ctrlD.aluSrc     = 1'b1;
            ctrlD.regWrite   = 1'b1;
          end
          OP2_B:   ctrlD.jump = 1'b1;
          OP2_BCC: begin
            ctrlD.bcc  = 1'b1;
            ctrlD.cond = instrD[10:8];
          end
          default: ctrlD = CTRL_BUBBLE;
        endcase
      end
      OP1_ALU: begin
        case (instrD[7:4])
          ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV,
          ALU_SLL, ALU_SLR, ALU_SRL, ALU_SRA, ALU_IN: begin
            ctrlD.aluControl = instrD[7:4];
            ctrlD.regWrite   = 1'b1;
            ctrlD.setFlags   = 1'b1;
          end
          ALU_CMP: begin
            ctrlD.aluControl = instrD[7:4];
            ctrlD.setFlags   = 1'b1;
          end
          ALU_OUT: ctrlD.aluControl = instrD[7:4];
          ALU_HLT: begin
            if (HALT_EN) begin
              ctrlD.aluControl = instrD[7:4];
              ctrlD.halt       = 1'b1;
            end
          end
          default: ctrlD = CTRL_BUBBLE;
        endcase
      end
      default: ctrlD = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes instrD, carries the control bundle through
// E, M and W, resolves branches in E against a flag register, and halts the
// pipeline on HLT.
//   clk, reset            : clock, synchronous active-high reset
//   instrD                : instruction in decode
//   SE, ZE, VE, CE        : ALU flags for the instruction in E
//   alusrcE, alucontrolE, jumpE : E-stage controls
//   pcsrcM                : registered branch-taken pulse
//   memwriteM             : M-stage store strobe
//   regwriteW, memtoregW  : W-stage write enable / load select
//   stallF, halted        : pipeline frozen in HALT
module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter bit HALT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instrD,
  input  logic        SE,
  input  logic        ZE,
  input  logic        VE,
  input  logic        CE,
  output logic        alusrcE,
  output logic [3:0]  alucontrolE,
  output logic        jumpE,
  output logic        pcsrcM,
  output logic        memwriteM,
  output logic        regwriteW,
  output logic        memtoregW,
  output logic        stallF,
  output logic        halted
);

  state_e     state, stateNext;
  ctrl_t      ctrlD, ctrlE, ctrlM, ctrlW;
  logic [3:0] flags;
  logic       eLive, taken, enterHalt;

  ctrl_decode #(.HALT_EN(HALT_EN)) uDecode (
    .instrD (instrD),
    .ctrlD  (ctrlD)
  );

  // The instruction in E while pcsrcM is high is one of the two being
  // squashed, so it may not branch, set flags or halt.
  always_comb begin
    eLive     = ~pcsrcM;
    taken     = eLive & (ctrlE.jump | (ctrlE.bcc & condMet(ctrlE.cond, flags)));
    enterHalt = HALT_EN & eLive & ctrlE.halt & (state == ST_RUN);
    stateNext = state;
    case (state)
      ST_RUN:  if (enterHalt) stateNext = ST_HALT;
      ST_HALT: stateNext = ST_HALT;
      default: stateNext = ST_RUN;
    endcase
  end

  // The instruction behind HLT is bubbled on the halting edge so that
  // nothing younger than HLT ever occupies E.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      flags  <= '0;
      ctrlE  <= CTRL_BUBBLE;
      ctrlM  <= CTRL_BUBBLE;
      ctrlW  <= CTRL_BUBBLE;
      pcsrcM <= 1'b0;
    end else begin
      state  <= stateNext;
      pcsrcM <= taken;
      if (eLive && ctrlE.setFlags) flags <= {SE, ZE, VE, CE};
      ctrlE  <= (pcsrcM || state == ST_HALT || enterHalt) ? CTRL_BUBBLE : ctrlD;
      ctrlM  <= (pcsrcM || state == ST_HALT) ? CTRL_BUBBLE : ctrlE;
      ctrlW  <= ctrlM;
    end
  end

  assign alusrcE     = ctrlE.aluSrc;
  assign alucontrolE = ctrlE.aluControl;
  assign jumpE       = ctrlE.jump;
  assign memwriteM   = ctrlM.memWrite;
  assign regwriteW   = ctrlW.regWrite;
  assign memtoregW   = ctrlW.memToReg;
  assign halted      = (state == ST_HALT);
  assign stallF      = halted;

endmodule

// File: tb/tb_pipe_controller.sv
module tb_pipe_controller;

  localparam logic [15:0] I_NOP = 16'h8800;
  localparam logic [15:0] I_ADD = 16'hC100;
  localparam logic [15:0] I_CMP = 16'hC050;
  localparam logic [15:0] I_LD  = 16'h0105;
  localparam logic [15:0] I_ST  = 16'h4105;
  localparam logic [15:0] I_LI  = 16'h8012;
  localparam logic [15:0] I_OUT = 16'hC0D0;
  localparam logic [15:0] I_HLT = 16'hC0F0;
  localparam logic [15:0] I_B   = 16'hA002;
  localparam logic [15:0] I_BE  = 16'hB803;
  localparam logic [15:0] I_BLT = 16'hB903;
  localparam logic [15:0] I_BLE = 16'hBA03;
  localparam logic [15:0] I_BNE = 16'hBB03;
  localparam logic [15:0] I_BNV = 16'hBC03;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instrD;
  logic        SE, ZE, VE, CE;

  logic       alusrcE, jumpE, pcsrcM, memwriteM, regwriteW, memtoregW, stallF, halted;
  logic [3:0] alucontrolE;
  logic       alusrcE2, jumpE2, pcsrcM2, memwriteM2, regwriteW2, memtoregW2, stallF2, halted2;
  logic [3:0] alucontrolE2;

  pipe_controller #(.HALT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instrD(instrD),
    .SE(SE), .ZE(ZE), .VE(VE), .CE(CE),
    .alusrcE(alusrcE), .alucontrolE(alucontrolE), .jumpE(jumpE),
    .pcsrcM(pcsrcM), .memwriteM(memwriteM),
    .regwriteW(regwriteW), .memtoregW(memtoregW),
    .stallF(stallF), .halted(halted)
  );

  pipe_controller #(.HALT_EN(1'b0)) dutNoHalt (
    .clk(clk), .reset(reset), .instrD(instrD),
    .SE(SE), .ZE(ZE), .VE(VE), .CE(CE),
    .alusrcE(alusrcE2), .alucontrolE(alucontrolE2), .jumpE(jumpE2),
    .pcsrcM(pcsrcM2), .memwriteM(memwriteM2),
    .regwriteW(regwriteW2), .memtoregW(memtoregW2),
    .stallF(stallF2), .halted(halted2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alusrc;
    logic [3:0] aluc;
    logic       jump;
    logic       bcc;
    logic [2:0] cond;
    logic       regw;
    logic       mtr;
    logic       memw;
    logic       setf;
    logic       halt;
  } dec_t;

  // Expected-output scoreboard: element 0 is the vector expected after the
  // next clock edge. Layout {halted, stallF, regwriteW, memtoregW,
  // memwriteM, pcsrcM, jumpE, alusrcE, alucontrolE[3:0]}.
  logic [11:0] expQ[$];

  int unsigned passCount = 0;
  int unsigned totalCount = 0;

  dec_t       eCtl;
  logic       eLive = 1'b0;
  logic       pcsNow = 1'b0;
  logic       haltModel = 1'b0;
  logic [3:0] flagsM = '0;
  logic [3:0] curF = '0;

  function automatic dec_t expDec(input logic [15:0] i);
    dec_t d;
    d = '0;
    case (i[15:14])
      2'b00: begin d.alusrc = 1'b1; d.regw = 1'b1; d.mtr = 1'b1; end
      2'b01: begin d.alusrc = 1'b1; d.memw = 1'b1; end
      2'b10: begin
        if (i[13:11] == 3'b000) begin d.aluc = 4'b0110; d.alusrc = 1'b1; d.regw = 1'b1; end
        else if (i[13:11] == 3'b100) d.jump = 1'b1;
        else if (i[13:11] == 3'b111) begin d.bcc = 1'b1; d.cond = i[10:8]; end
      end
      default: begin
        if (i[7:4] <= 4'b1011) begin
          d.aluc = i[7:4]; d.setf = 1'b1; d.regw = (i[7:4] != 4'b0101);
        end else if (i[7:4] == 4'b1101) d.aluc = i[7:4];
        else if (i[7:4] == 4'b1111) begin d.aluc = i[7:4]; d.halt = 1'b1; end
      end
    endcase
    return d;
  endfunction

  function automatic logic condOk(input logic [2:0] c, input logic [3:0] f);
    logic s, z, v;
    s = f[3]; z = f[2]; v = f[1];
    case (c)
      3'b000:  return z;
      3'b001:  return s ^ v;
      3'b010:  return z | (s ^ v);
      3'b011:  return ~z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] obsVec();
    return {halted, stallF, regwriteW, memtoregW, memwriteM, pcsrcM,
            jumpE, alusrcE, alucontrolE};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    instrD = I_NOP;
    {SE, ZE, VE, CE} = 4'b0;
    @(posedge clk); #1;
    check({tag, "_edge1"}, obsVec(), 12'h000);
    @(posedge clk); #1;
    check({tag, "_edge2"}, obsVec(), 12'h000);
    check({tag, "_nohalt"}, {halted2, stallF2, regwriteW2, memtoregW2, memwriteM2,
                             pcsrcM2, jumpE2, alusrcE2, alucontrolE2}, 12'h000);
    reset = 1'b0;
    expQ.delete();
    eLive = 1'b0; pcsNow = 1'b0; haltModel = 1'b0; flagsM = '0; curF = '0;
  endtask

  // Drive ins into D for one cycle; f = {S,Z,V,C} presented while ins is in E.
  task automatic step(input string tag, input logic [15:0] ins, input logic [3:0] f);
    logic        taken, halting, enterE;
    logic [11:0] exp;
    dec_t        d;
    taken = 1'b0;
    halting = 1'b0;
    while (expQ.size() < 2) expQ.push_back('0);
    if (eLive && !pcsNow) begin
      taken = eCtl.jump || (eCtl.bcc && condOk(eCtl.cond, flagsM));
      if (eCtl.setf) flagsM = curF;
      halting = eCtl.halt;
      if (eCtl.memw) expQ[0] = expQ[0] | 12'h080;
      if (eCtl.regw) expQ[1] = expQ[1] | 12'h200;
      if (eCtl.mtr)  expQ[1] = expQ[1] | 12'h100;
    end
    enterE = !pcsNow && !haltModel && !halting;
    if (enterE) begin
      d = expDec(ins);
      expQ[0] = expQ[0] | {6'b0, d.jump, d.alusrc, d.aluc};
      eCtl = d;
      eLive = 1'b1;
    end else begin
      eLive = 1'b0;
    end
    pcsNow = taken;
    haltModel = haltModel | halting;
    instrD = ins;
    @(posedge clk); #1;
    {SE, ZE, VE, CE} = f;
    curF = f;
    exp = expQ.pop_front() | (pcsNow ? 12'h040 : 12'h000) | (haltModel ? 12'hC00 : 12'h000);
    check(tag, obsVec(), exp);
    check({tag, "_nohalt"}, {10'b0, halted2, stallF2}, 12'h000);
  endtask

  initial begin
    reset = 1'b1;
    instrD = I_NOP;
    {SE, ZE, VE, CE} = 4'b0;
    doReset("por");

    // ALU, loads, stores, LI, OUT
    step("add",  I_ADD, 4'b0000);
    step("ld",   I_LD,  4'b0000);
    step("st",   I_ST,  4'b0000);
    step("li",   I_LI,  4'b0000);
    step("out",  I_OUT, 4'b0000);
    step("drn0", I_NOP, 4'b0000);
    step("drn1", I_NOP, 4'b0000);

    // BE taken after CMP with Z, two younger instructions squashed
    step("cmpz", I_CMP, 4'b0100);
    step("be",   I_BE,  4'b0000);
    step("sq0",  I_ADD, 4'b0000);
    step("sq1",  I_ST,  4'b0000);
    step("sq2",  I_NOP, 4'b0000);
    step("sq3",  I_NOP, 4'b0000);

    // BLT with S=V not taken, with S!=V taken
    step("cmpsv", I_CMP, 4'b1010);
    step("blt0",  I_BLT, 4'b0000);
    step("blt0a", I_NOP, 4'b0000);
    step("cmps",  I_CMP, 4'b1000);
    step("blt1",  I_BLT, 4'b0000);
    step("blt1a", I_NOP, 4'b0000);
    step("blt1b", I_NOP, 4'b0000);

    // BNE/BLE/never-taken codes with clear flags; flags survive LD/ST
    step("cmp0",  I_CMP, 4'b0000);
    step("ble",   I_BLE, 4'b0000);
    step("bnv",   I_BNV, 4'b0000);
    step("bne",   I_BNE, 4'b0000);
    step("bnea",  I_NOP, 4'b0000);
    step("bneb",  I_NOP, 4'b0000);
    step("cmpz2", I_CMP, 4'b0100);
    step("ldf",   I_LD,  4'b0000);
    step("stf",   I_ST,  4'b1011);
    step("be2",   I_BE,  4'b0000);
    step("be2a",  I_NOP, 4'b0000);
    step("be2b",  I_NOP, 4'b0000);

    // squashed CMP must not update flags; back-to-back B fires once
    step("cmp0b", I_CMP, 4'b0000);
    step("bsq",   I_B,   4'b0000);
    step("cmpsq", I_CMP, 4'b0100);
    step("bsqa",  I_NOP, 4'b0000);
    step("bsqb",  I_NOP, 4'b0000);
    step("be3",   I_BE,  4'b0000);
    step("be3a",  I_NOP, 4'b0000);
    step("bb0",   I_B,   4'b0000);
    step("bb1",   I_B,   4'b0000);
    step("bb2",   I_NOP, 4'b0000);
    step("bb3",   I_NOP, 4'b0000);

    // reset mid-branch
    step("mb0",   I_B,   4'b0000);
    step("mb1",   I_ADD, 4'b0000);
    doReset("rstbr");

    // B then HLT: HLT squashed, no halt
    step("bh0",   I_B,   4'b0000);
    step("bh1",   I_HLT, 4'b0000);
    step("bh2",   I_NOP, 4'b0000);
    step("bh3",   I_NOP, 4'b0000);

    // HLT then ADD: halt, ADD never reaches W; HALT_EN=0 copy runs the ADD
    step("h0",    I_HLT, 4'b0000);
    check("nohalt_hlt_e", {7'b0, alusrcE2, jumpE2, alucontrolE2}, 12'h000);
    step("h1",    I_ADD, 4'b0000);
    step("h2",    I_NOP, 4'b0000);
    step("h3",    I_NOP, 4'b0000);
    check("nohalt_add_w", {8'b0, regwriteW2, memtoregW2, memwriteM2, pcsrcM2}, 12'h008);
    step("h4",    I_LD,  4'b0000);
    step("h5",    I_NOP, 4'b0000);
    doReset("rsthalt");
    step("r0",    I_ADD, 4'b0000);
    step("r1",    I_NOP, 4'b0000);
    step("r2",    I_NOP, 4'b0000);
    step("r3",    I_NOP, 4'b0000);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
